// File: rtl/imem_boot_loader.sv
// Boot loader for the instruction memory: packs a byte stream into
// little-endian 32-bit words, writes them from address 0 upward while the
// core is held in reset, then releases the core and hands the memory
// address over to the core's fetch PC.
module imem_boot_loader #(
  parameter int XLEN      = 5,
  parameter int MAX_WORDS = 2 ** (XLEN - 2)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-2:0] len_words,
  input  logic            byte_valid,
  input  logic [7:0]      byte_data,
  output logic            byte_ready,
  input  logic [31:0]     pc_in,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [31:0]     mem_wdata,
  output logic            core_hold,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR} state_t;

  localparam logic [XLEN-1:0] MAX_LEN = XLEN'(MAX_WORDS);

  state_t          state;
  state_t          state_n;
  logic [XLEN-2:0] len_q;
  logic [XLEN-3:0] word_idx;
  logic [1:0]      byte_cnt;
  logic [XLEN-2:0] idx_inc;
  logic            start_ok;
  logic            xfer;

  // Start is only honoured when no load is in flight.
  assign start_ok = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign xfer     = (state == RECV) && byte_valid && byte_ready;
  assign idx_inc  = {1'b0, word_idx} + {{(XLEN-2){1'b0}}, 1'b1};

  // Once the core runs it owns the memory address; otherwise the write pointer does.
  assign mem_addr = (state == DONE) ? pc_in[XLEN-1:0] : {word_idx, 2'b00};

  // Next-state selection, including the length checks on every accepted start.
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (start_ok) begin
          if (len_words == '0)                  state_n = DONE;
          else if ({1'b0, len_words} > MAX_LEN) state_n = ERR;
          else                                  state_n = RECV;
        end
      end
      RECV:    if (xfer && (byte_cnt == 2'd3)) state_n = WRITE;
      WRITE:   state_n = (idx_inc == len_q) ? DONE : RECV;
      default: state_n = IDLE;
    endcase
  end

  // State, datapath and outputs registered together; outputs decode the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_q      <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      mem_wdata  <= '0;
      core_hold  <= 1'b1;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state <= state_n;

      if (start_ok) begin
        len_q    <= len_words;
        word_idx <= '0;
        byte_cnt <= '0;
      end

      if (xfer) begin
        mem_wdata[8*byte_cnt +: 8] <= byte_data;
        byte_cnt                   <= byte_cnt + 2'd1;
      end

      if (state == WRITE) begin
        word_idx <= idx_inc[XLEN-3:0];
      end

      core_hold  <= (state_n != DONE);
      byte_ready <= (state_n == RECV);
      mem_we     <= (state_n == WRITE);
      busy       <= (state_n == RECV) || (state_n == WRITE);
      done       <= (state_n == DONE);
      err        <= (state_n == ERR);
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: reset, streaming loads with and
// without backpressure, length bounds, run/reload and mid-load reset.
module tb_imem_boot_loader;

  localparam int XLEN = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [XLEN-2:0] len_words;
  logic            byte_valid;
  logic [7:0]      byte_data;
  logic            byte_ready;
  logic [31:0]     pc_in;
  logic [XLEN-1:0] mem_addr;
  logic            mem_we;
  logic [31:0]     mem_wdata;
  logic            core_hold;
  logic            busy;
  logic            done;
  logic            err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [XLEN-1:0] waddr[$];
  logic [31:0]     wdata[$];
  logic [7:0]      stream[$];

  imem_boot_loader #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .len_words(len_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .pc_in(pc_in), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Record every write strobe cycle; the loader must never offer ready while writing.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      waddr.push_back(mem_addr);
      wdata.push_back(mem_wdata);
      n_assert++;
      assert (byte_ready === 1'b0) else begin
        n_fail++;
        $error("FAIL ready_in_write: observed %0b expected 0", byte_ready);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!byte_ready && n < 20) begin
      step();
      n++;
    end
    if (!byte_ready) chk("ready_timeout", {31'd0, byte_ready}, 32'd1);
  endtask

  // Pulse start, then push the stream; with bp the valid drops for a cycle
  // after each byte except the 4th of a word, whose successor is offered
  // during the WRITE cycle. Returns in the cycle after the last transfer.
  task automatic do_load(input logic [XLEN-2:0] len, input bit bp);
    start = 1'b1;
    len_words = len;
    step();
    start = 1'b0;
    foreach (stream[i]) begin
      byte_valid = 1'b1;
      byte_data  = stream[i];
      wait_ready();
      step();
      if (bp && (i % 4) != 3) begin
        byte_valid = 1'b0;
        byte_data  = 8'hEE;
        step();
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic set_prog3();
    stream = '{8'h13, 8'h04, 8'h00, 8'h01, 8'h93, 8'h04, 8'h10, 8'h10,
               8'h33, 8'h89, 8'h84, 8'h00};
  endtask

  task automatic chk_prog3(input string tag);
    chk({tag, "_nwr"}, waddr.size(), 32'd3);
    if (waddr.size() == 3) begin
      chk({tag, "_a0"}, {27'd0, waddr[0]}, 32'h0);
      chk({tag, "_a1"}, {27'd0, waddr[1]}, 32'h4);
      chk({tag, "_a2"}, {27'd0, waddr[2]}, 32'h8);
      chk({tag, "_d0"}, wdata[0], 32'h01000413);
      chk({tag, "_d1"}, wdata[1], 32'h10100493);
      chk({tag, "_d2"}, wdata[2], 32'h00848933);
    end
  endtask

  initial begin
    // Reset with random inputs
    rst = 1'b1;
    start = 1'($urandom);
    len_words = 4'($urandom);
    byte_valid = 1'($urandom);
    byte_data = 8'($urandom);
    pc_in = $urandom;
    step();
    step();
    chk("rst_hold", {31'd0, core_hold}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_addr", {27'd0, mem_addr}, 32'd0);
    rst = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    len_words = '0;
    pc_in = 32'h0;
    step();

    // Happy path: three words, valid held high
    set_prog3();
    waddr.delete(); wdata.delete();
    do_load(4'd3, 1'b0);
    chk("hp_we_last", {31'd0, mem_we}, 32'd1);
    chk("hp_done_wr", {31'd0, done}, 32'd0);
    chk("hp_busy", {31'd0, busy}, 32'd1);
    step();
    chk("hp_done", {31'd0, done}, 32'd1);
    chk("hp_hold", {31'd0, core_hold}, 32'd0);
    chk("hp_we_off", {31'd0, mem_we}, 32'd0);
    chk_prog3("hp");

    // Backpressure: toggled valid, valid high during WRITE cycles
    waddr.delete(); wdata.delete();
    do_load(4'd3, 1'b1);
    step();
    chk("bp_done", {31'd0, done}, 32'd1);
    chk_prog3("bp");

    // Zero length completes immediately with no writes
    waddr.delete(); wdata.delete();
    start = 1'b1; len_words = 4'd0;
    step();
    start = 1'b0;
    chk("len0_done", {31'd0, done}, 32'd1);
    step();
    chk("len0_nwr", waddr.size(), 32'd0);

    // Over-long request is rejected
    start = 1'b1; len_words = 4'd9;
    step();
    start = 1'b0;
    chk("len9_err", {31'd0, err}, 32'd1);
    chk("len9_hold", {31'd0, core_hold}, 32'd1);
    chk("len9_done", {31'd0, done}, 32'd0);
    step();
    chk("len9_nwr", waddr.size(), 32'd0);

    // Retry from ERR with one word
    stream = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    start = 1'b1; len_words = 4'd1;
    step();
    start = 1'b0;
    chk("retry_err", {31'd0, err}, 32'd0);
    foreach (stream[i]) begin
      byte_valid = 1'b1; byte_data = stream[i];
      wait_ready();
      step();
    end
    byte_valid = 1'b0;
    step();
    chk("retry_done", {31'd0, done}, 32'd1);
    chk("retry_nwr", waddr.size(), 32'd1);
    if (waddr.size() == 1) begin
      chk("retry_addr", {27'd0, waddr[0]}, 32'h0);
      chk("retry_data", wdata[0], 32'hDDCCBBAA);
    end

    // Run: memory address follows pc_in
    pc_in = 32'h0000_0008;
    #1;
    chk("run_addr8", {27'd0, mem_addr}, 32'h08);
    chk("run_we", {31'd0, mem_we}, 32'd0);
    pc_in = 32'h0000_002C;
    #1;
    chk("run_addr2c", {27'd0, mem_addr}, 32'h0C);

    // Reload from DONE
    waddr.delete(); wdata.delete();
    stream = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_load(4'd1, 1'b0);
    step();
    chk("reload_done", {31'd0, done}, 32'd1);
    chk("reload_nwr", waddr.size(), 32'd1);
    if (waddr.size() == 1) chk("reload_data", wdata[0], 32'h44332211);
    start = 1'b1; len_words = 4'd1;
    step();
    start = 1'b0;
    chk("reload_hold", {31'd0, core_hold}, 32'd1);
    chk("reload_done0", {31'd0, done}, 32'd0);

    // Abort: reset after two bytes of the pending word
    waddr.delete(); wdata.delete();
    byte_valid = 1'b1; byte_data = 8'h55;
    wait_ready(); step();
    byte_data = 8'h66;
    wait_ready(); step();
    byte_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("abort_nwr", waddr.size(), 32'd0);
    chk("abort_addr", {27'd0, mem_addr}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hold", {31'd0, core_hold}, 32'd1);
    chk("abort_ready", {31'd0, byte_ready}, 32'd0);

    // Full load after abort starts at address 0
    set_prog3();
    do_load(4'd3, 1'b0);
    step();
    chk("post_done", {31'd0, done}, 32'd1);
    chk_prog3("post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot-time controller for the byte-addressed instruction memory (2**XLEN bytes, little-endian words).
- Accepts a program as a valid/ready byte stream, packs every 4 bytes into a 32-bit word, and issues one write per word starting at address 0.
- Holds the core in reset while loading, then releases it.
- Muxes the memory address between the loader's write pointer and the core's fetch PC.

Parameters:
- XLEN, 5, instruction-memory byte-address width; memory depth is 2**XLEN bytes.
- MAX_WORDS, 2**(XLEN-2), maximum loadable words.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle load request.
- len_words  in  XLEN-1  number of words to load; sampled when start is accepted.
- byte_valid  in  1  stream byte present.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- pc_in  in  32  core fetch address.
- mem_addr  out  XLEN  address to the instruction memory.
- mem_we  out  1  word write strobe.
- mem_wdata  out  32  assembled word.
- core_hold  out  1  high = core held in reset.
- busy  out  1  load in progress.
- done  out  1  load complete; core running.
- err  out  1  rejected load length.

Behaviour:
- Clock/reset (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, core_hold=1, byte_ready=0, mem_we=0, mem_wdata=0, busy=0, done=0, err=0, word_idx=0, byte_cnt=0, mem_addr=0.
- FSM states: IDLE, RECV, WRITE, DONE, ERR. All outputs decode from registered state, except mem_addr in DONE.
- IDLE:
  - On start, capture len_words.
  - len_words=0 -> DONE.
  - len_words>MAX_WORDS -> ERR.
  - Otherwise -> RECV, with word_idx=0 and byte_cnt=0.
- RECV:
  - byte_ready=1, busy=1.
  - A byte transfers when byte_valid && byte_ready.
  - Byte k (byte_cnt=k) is written to mem_wdata[8k+7:8k].
  - byte_cnt increments per transfer and wraps 3->0.
  - On the 4th transfer -> WRITE.
  - byte_valid low -> stay in RECV; no timeout.
- WRITE:
  - Exactly one cycle: mem_we=1, mem_addr={word_idx,2'b00}, byte_ready=0 (no transfer this cycle).
  - word_idx increments.
  - If word_idx+1==len -> DONE, else -> RECV.
- DONE:
  - core_hold=0, done=1, busy=0, mem_we=0.
  - mem_addr=pc_in[XLEN-1:0], combinational.
  - start -> reload: core_hold=1 and done=0 from the next cycle; length checks as in IDLE.
- ERR:
  - err=1, core_hold=1.
  - start retries with the length checks as in IDLE; err clears on leaving ERR.
- Address mux outside DONE: mem_addr={word_idx,2'b00}.
- Ignored start: start during RECV or WRITE is ignored.
- Latency and throughput:
  - Write strobe occurs the cycle after the 4th byte transfer.
  - Minimum 5 cycles per word.
  - done rises the cycle after the final WRITE.
- Reset mid-load: rst aborts immediately to reset values. The partial word is discarded and no write is issued.
- Write-pointer wrap: word_idx never exceeds MAX_WORDS-1, because len is bounded.

Test Plan:
- Reset: assert rst 2 cycles with random inputs -> all outputs at reset values; core_hold=1, done=0.
- Happy path:
  - Stimulus: start, len_words=3, byte_valid held high, bytes 13 04 00 01 93 04 10 10 33 89 84 00.
  - Required: writes at mem_addr 0/4/8 with data 0x01000413 / 0x10100493 / 0x00848933, each mem_we exactly 1 cycle.
  - done=1 and core_hold=0 one cycle after the 3rd write.
- Backpressure:
  - Stimulus: same stream with byte_valid toggling 1/0, plus byte_valid high during WRITE cycles.
  - Required: identical writes; no byte consumed in a WRITE cycle; byte_ready=0 there.
- Bounds:
  - len_words=0 -> done next cycle, no mem_we.
  - len_words=9 (XLEN=5, MAX_WORDS=8) -> err=1, core_hold=1, no writes.
  - Then start with len=1 and 4 bytes -> err clears and one write occurs at addr 0.
- Run and reload:
  - In DONE, pc_in=0x00000008 -> mem_addr=8, mem_we=0; pc_in=0x0000002C -> mem_addr=0x0C.
  - start with len=1 -> core_hold=1 next cycle, done=0.
- Abort: rst after 2 bytes of word 1 -> no mem_we, word_idx=0, IDLE. A subsequent full load writes from address 0.
